phy_rx_lanes: RTL
=================

Name: phy_rx_lanes

Overview:
Parametrised single-clock receive PHY that generalises the two-lane receive path to LANES lanes.
- Each lane deserialises a serial bitstream and bit-aligns on a COM symbol.
- Each lane assembles symbols into WORD_W words.
- Words from all lanes are unstriped round-robin into one output word stream.
- Sits between the serial lane inputs and the link-layer receive FIFO, replacing the multi-clock serial-to-parallel, mux and unstriping chain with one bit-rate clock domain.

Parameters:
LANES, 2, number of serial lanes (1..8)
SYM_W, 8, symbol width in bits
WORD_W, 32, output word width; must be an integer multiple of SYM_W; BPW = WORD_W/SYM_W
COM, 8'hBC, alignment/comma symbol
IDL, 8'h7C, idle symbol
ALIGN_COUNT, 4, consecutive aligned COMs required to declare a lane active

Ports:
clk_32f  input  1  bit-rate clock; all logic is on the rising edge
reset_L  input  1  asynchronous active-low reset
data_in  input  LANES  serial data, one bit per lane per cycle, MSB of each symbol first
data_out  output  WORD_W  unstriped word; first received symbol lands in the MSBs
valid_out  output  1  one-cycle strobe, data_out is valid
active  output  LANES  per-lane aligned/active flag
overflow  output  1  sticky flag, a lane word was dropped

Behaviour:
Reset (reset_L=0, asynchronous):
- data_out=0, valid_out=0, active=0, overflow=0.
- All shift registers, bit counters, COM counters, byte counters and holding registers are cleared.
- Round-robin pointer = 0; every lane aligner in SEARCH.
- Asserting reset mid-word discards all partial state; no valid_out may follow reset release until a lane realigns.

Per-lane shifter:
- sr <= {sr[SYM_W-2:0], data_in[i]} every cycle.

Per-lane aligner FSM (states SEARCH, LOCKING, ACTIVE):
- SEARCH: every cycle compare sr to COM. On match: bit counter <= 0, com_cnt <= 1, go to LOCKING. Bit offset is arbitrary.
- Symbol boundary: the bit counter wraps SYM_W-1 -> 0, i.e. every SYM_W cycles after the detecting COM.
- LOCKING: at each boundary, if sr==COM then com_cnt++. When com_cnt reaches ALIGN_COUNT, go to ACTIVE and set active[i]=1 on that same edge. If sr!=COM at a boundary, return to SEARCH with com_cnt=0.
- ACTIVE: sticky until reset. At each boundary:
  - COM or IDL symbol: no byte is produced and the lane byte counter is cleared (partial word discarded).
  - Any other symbol: it is a data byte.

Per-lane word assembly:
- Data bytes shift into the lane word MSB-first.
- On the BPW-th byte, the word is written into the lane holding register (full=1) on the next edge, and the byte counter returns to 0.
- If the holding register is full and not being drained that cycle, the new word is dropped and overflow <= 1 (sticky until reset).
- Drain and fill of the same lane in the same cycle: the new word is accepted.

Unstriper:
- When the holding register of lane ptr is full, on the next edge: data_out <= word, valid_out <= 1, clear that holding register, ptr <= (ptr==LANES-1) ? 0 : ptr+1.
- Otherwise valid_out <= 0 and data_out holds its last value.
- ptr never skips a lane: an inactive lane stalls the output stream.
- At most one word is output per cycle.

Latency:
- The last bit of a word's final byte enters sr at edge E.
- Holding register is full at E+1.
- valid_out is high during the cycle after edge E+2 when ptr already points to that lane.

Test Plan:
1. Reset: hold reset_L=0 with random data_in -> all outputs 0. Release, then drive reset_L=0 mid-word on an active lane -> active=0 immediately; no valid_out after release until 4 COMs are received again.
2. Alignment (LANES=2): lane0 sends 4x 8'hBC starting at bit offset 3 -> active[0] rises on the edge where the 4th COM completes. Lane1 sends BC,BC,BC,55 -> active[1] stays 0; 4 further COMs -> active[1]=1.
3. Two-lane unstriping: both lanes active; lane0 sends DE AD BE EF, lane1 sends 01 23 45 67 -> valid_out pulses exactly twice, one cycle each: 32'hDEADBEEF then 32'h01234567.
4. Partial word: lane0 sends AA BB, IDL, then 11 22 33 44, and lane1 sends 55 66 77 88 -> outputs 32'h11223344 then 32'h55667788; no word containing AA or BB ever appears.
5. Overflow: lane1 active but idle; lane0 sends words W0, W1, W2 -> W0 output, ptr stalls on lane1, W1 is held, W2 sets overflow=1. Then lane1 sends W3 -> outputs W3, then W1; overflow stays 1.
6. LANES=4, WORD_W=64: four active lanes each send one word -> four valid_out pulses in lane order 0,1,2,3, and ptr wraps back to 0.

Source files
------------

// File: rtl/phy_rx_lanes.sv
// rtl/phy_rx_lanes.sv - multi-lane serial receive PHY: per-lane COM alignment, word assembly, round-robin unstriping
module phy_rx_lanes #(
    parameter int               LANES       = 2,
    parameter int               SYM_W       = 8,
    parameter int               WORD_W      = 32,
    parameter logic [SYM_W-1:0] COM         = 8'hBC,
    parameter logic [SYM_W-1:0] IDL         = 8'h7C,
    parameter int               ALIGN_COUNT = 4
) (
    input  logic              clk_32f,
    input  logic              reset_L,
    input  logic [LANES-1:0]  data_in,
    output logic [WORD_W-1:0] data_out,
    output logic              valid_out,
    output logic [LANES-1:0]  active,
    output logic              overflow
);
    localparam int BPW    = WORD_W / SYM_W;
    localparam int BIT_W  = (SYM_W > 1) ? $clog2(SYM_W) : 1;
    localparam int BCNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int CCNT_W = $clog2(ALIGN_COUNT + 1);
    localparam int PTR_W  = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {SEARCH, LOCKING, ACTIVE} state_t;

    logic [WORD_W-1:0] w_lane_word [LANES];
    logic [LANES-1:0]  w_fill;
    logic [LANES-1:0]  w_drain;
    logic [WORD_W-1:0] w_drain_word;
    logic [WORD_W-1:0] r_hold [LANES];
    logic [LANES-1:0]  r_full;
    logic [PTR_W-1:0]  r_ptr;
    logic [WORD_W-1:0] r_data_out;
    logic              r_valid_out;
    logic              r_overflow;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            state_t            r_state, w_state_next;
            logic [SYM_W-1:0]  r_sr;
            logic [BIT_W-1:0]  r_bit_cnt, w_bit_cnt_next;
            logic [CCNT_W-1:0] r_com_cnt, w_com_cnt_next;
            logic [BCNT_W-1:0] r_byte_cnt, w_byte_cnt_next;
            logic [WORD_W-1:0] r_word, w_word_next;
            logic              w_boundary, w_is_com, w_is_idl, w_fill_l;

            always_ff @(posedge clk_32f or negedge reset_L) begin
                if (!reset_L) begin
                    r_state    <= SEARCH;
                    r_sr       <= '0;
                    r_bit_cnt  <= '0;
                    r_com_cnt  <= '0;
                    r_byte_cnt <= '0;
                    r_word     <= '0;
                end else begin
                    r_state    <= w_state_next;
                    r_sr       <= {r_sr[SYM_W-2:0], data_in[gi]};
                    r_bit_cnt  <= w_bit_cnt_next;
                    r_com_cnt  <= w_com_cnt_next;
                    r_byte_cnt <= w_byte_cnt_next;
                    r_word     <= w_word_next;
                end
            end

            // Symbol boundaries are judged on the registered shifter, one edge after the last bit lands.
            always_comb begin
                w_is_com        = (r_sr == COM);
                w_is_idl        = (r_sr == IDL);
                w_boundary      = (r_bit_cnt == BIT_W'(SYM_W - 1));
                w_state_next    = r_state;
                w_bit_cnt_next  = w_boundary ? '0 : r_bit_cnt + BIT_W'(1);
                w_com_cnt_next  = r_com_cnt;
                w_byte_cnt_next = r_byte_cnt;
                w_word_next     = r_word;
                w_fill_l        = 1'b0;
                case (r_state)
                    SEARCH: begin
                        if (w_is_com) begin
                            w_bit_cnt_next = '0;
                            w_com_cnt_next = CCNT_W'(1);
                            w_state_next   = (ALIGN_COUNT <= 1) ? ACTIVE : LOCKING;
                        end
                    end
                    LOCKING: begin
                        if (w_boundary) begin
                            if (w_is_com) begin
                                w_com_cnt_next = r_com_cnt + CCNT_W'(1);
                                if (r_com_cnt + CCNT_W'(1) >= CCNT_W'(ALIGN_COUNT))
                                    w_state_next = ACTIVE;
                            end else begin
                                w_com_cnt_next = '0;
                                w_state_next   = SEARCH;
                            end
                        end
                    end
                    ACTIVE: begin
                        if (w_boundary) begin
                            if (w_is_com || w_is_idl) begin
                                w_byte_cnt_next = '0;
                            end else begin
                                w_word_next = WORD_W'({r_word, r_sr});
                                if (r_byte_cnt == BCNT_W'(BPW - 1)) begin
                                    w_byte_cnt_next = '0;
                                    w_fill_l        = 1'b1;
                                end else begin
                                    w_byte_cnt_next = r_byte_cnt + BCNT_W'(1);
                                end
                            end
                        end
                    end
                    default: w_state_next = SEARCH;
                endcase
            end

            assign w_lane_word[gi] = w_word_next;
            assign w_fill[gi]      = w_fill_l;
            assign active[gi]      = (r_state == ACTIVE);
        end
    endgenerate

    always_comb begin
        w_drain      = '0;
        w_drain_word = '0;
        for (int i = 0; i < LANES; i++) begin
            w_drain[i] = r_full[i] && (r_ptr == PTR_W'(i));
            if (w_drain[i]) w_drain_word = r_hold[i];
        end
    end

    // A lane may refill its holding register on the same edge the unstriper empties it.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            r_full      <= '0;
            r_ptr       <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_overflow  <= 1'b0;
            for (int i = 0; i < LANES; i++) r_hold[i] <= '0;
        end else begin
            r_valid_out <= |w_drain;
            if (|w_drain) begin
                r_data_out <= w_drain_word;
                r_ptr      <= (r_ptr == PTR_W'(LANES - 1)) ? '0 : r_ptr + PTR_W'(1);
            end
            for (int i = 0; i < LANES; i++) begin
                if (w_fill[i]) begin
                    if (!r_full[i] || w_drain[i]) begin
                        r_hold[i] <= w_lane_word[i];
                        r_full[i] <= 1'b1;
                    end else begin
                        r_overflow <= 1'b1;
                    end
                end else if (w_drain[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign overflow  = r_overflow;
endmodule
